// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Channel config is {period, high}; clamp_cfg makes a raw write safe before it goes live.
package clkdiv_pkg;

  localparam int CNT_W      = 32;
  localparam int MIN_PERIOD = 2;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } chan_cfg_t;

  // high is judged against the raw period, so a tiny period with any high time becomes
  // constant-high. Setting high to the clamped period keeps phase < high true every cycle.
  function automatic chan_cfg_t clamp_cfg(input chan_cfg_t raw);
    chan_cfg_t c;
    c.period = (raw.period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : raw.period;
    if (raw.high == '0) begin
      c.high = '0;
    end else if (raw.high >= raw.period) begin
      c.high = c.period;
    end else begin
      c.high = raw.high;
    end
    return c;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, shadow/active config, apply-at-period-start logic,
// registered divided clock and start-of-period tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DEF_PERIOD = 100,
  parameter int DEF_HIGH   = 50
) (
  input  logic      clk_100M,
  input  logic      rst_n,
  input  logic      en,
  input  logic      sync,
  input  logic      wr_en,
  input  chan_cfg_t wr_cfg,
  output logic      pend,
  output logic      clk_out,
  output logic      tick
);

  localparam chan_cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};
  localparam chan_cfg_t DEF_ACT = clamp_cfg(DEF_CFG);

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;
  logic             running;
  logic             restart;
  logic             apply;
  chan_cfg_t        act_cfg;
  chan_cfg_t        act_nxt;
  chan_cfg_t        shd_cfg;

  // A new period starts on the first enabled edge, on sync, or on wrap. Config only changes
  // at such a boundary (or while idle), so the running period never sees a runt.
  always_comb begin
    restart   = 1'b0;
    apply     = 1'b0;
    act_nxt   = act_cfg;
    phase_nxt = '0;
    restart   = !running || sync || (phase == (act_cfg.period - CNT_W'(1)));
    apply     = pend && (!en || restart);
    if (apply) begin
      act_nxt = clamp_cfg(shd_cfg);
    end
    phase_nxt = restart ? '0 : (phase + CNT_W'(1));
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      act_cfg <= DEF_ACT;
      shd_cfg <= DEF_CFG;
      pend    <= 1'b0;
      running <= 1'b0;
      phase   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      act_cfg <= act_nxt;
      // A write on an apply edge is held for the next boundary; the old shadow goes live now.
      if (wr_en) begin
        shd_cfg <= wr_cfg;
        pend    <= 1'b1;
      end else if (apply) begin
        pend    <= 1'b0;
      end
      if (en) begin
        running <= 1'b1;
        phase   <= phase_nxt;
        clk_out <= (phase_nxt < act_nxt.high);
        tick    <= restart;
      end else begin
        running <= 1'b0;
        phase   <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clkdiv_prog.sv
// Multi-channel runtime-programmable clock divider / clock-enable generator on clk_100M.
// CNT_W must match clkdiv_pkg::CNT_W, which sizes the channel config struct.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = clkdiv_pkg::CNT_W,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_HIGH   = 50,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // Config port: cfg_we is a one-cycle strobe with no ready; every strobe is taken on the edge
  // that samples it. An address with no matching channel simply selects nobody.
  chan_cfg_t wr_cfg;

  assign wr_cfg = '{period: cfg_period, high: cfg_high};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;

    assign wr_en = cfg_we && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk_100M (clk_100M),
      .rst_n    (rst_n),
      .en       (ch_en[i]),
      .sync     (sync),
      .wr_en    (wr_en),
      .wr_cfg   (wr_cfg),
      .pend     (cfg_pend[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule
